// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the frame-buffer write arbiter: default geometry,
// FSM state encoding and the grant identifiers used for round-robin fairness.
package fb_pkg;

   localparam int FB_ADDR_W = 12;
   localparam int FB_DATA_W = 8;
   localparam int FB_DEPTH  = 4096;

   typedef enum logic {
      FB_IDLE,
      FB_FILL
   } fb_state_t;

   typedef enum logic {
      GNT_LOADER,
      GNT_FILL
   } fb_grant_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundles the loader valid/ready handshake and the frame-buffer write port.
// The master modport is the arbiter side; the slave modport is the side that
// supplies loader writes and observes the memory port.
interface fb_write_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
) ();

   logic              LdValid;
   logic              LdReady;
   logic [ADDR_W-1:0] LdAddr;
   logic [DATA_W-1:0] LdData;
   logic [ADDR_W-1:0] MemAddress;
   logic [DATA_W-1:0] MemData;
   logic              MemWr;
   logic              MemClockEn;

   modport master (
      input  LdValid,
      input  LdAddr,
      input  LdData,
      output LdReady,
      output MemAddress,
      output MemData,
      output MemWr,
      output MemClockEn
   );

   modport slave (
      output LdValid,
      output LdAddr,
      output LdData,
      input  LdReady,
      input  MemAddress,
      input  MemData,
      input  MemWr,
      input  MemClockEn
   );

endinterface

// File: rtl/fb_write_arbiter_fill_counter.sv
// Fill address counter: steps through 0..DEPTH-1, one step per fill grant,
// and flags the final address so the arbiter knows when the fill ends.
module fb_fill_counter #(
   parameter int W     = 12,
   parameter int DEPTH = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count,
   output logic         terminal
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   // Clear wins over enable so a finishing or restarting fill always lands on 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: owns the buffer's byte write port and shares it
// between the byte loader (valid/ready) and an internal whole-buffer fill
// engine. Loader and fill alternate when both want the port.
// Optional build macro FB_FILL_ABORT_EN adds a FillAbort input that cancels
// a running fill without a FillDone pulse.
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FILL_DEPTH = FB_DEPTH
) (
   input  logic              Clock,
   input  logic              ResetN,
   fb_write_arbiter_if.master bus,
   input  logic              FillStart,
   input  logic [DATA_W-1:0] FillData,
`ifdef FB_FILL_ABORT_EN
   input  logic              FillAbort,
`endif
   output logic              FillBusy,
   output logic              FillDone
);

   fb_state_t         state_q;
   fb_grant_t         last_grant_q;
   logic [DATA_W-1:0] fill_byte_q;
   logic [ADDR_W-1:0] fill_count;
   logic              fill_last;
   logic              ld_ready;
   logic              ld_grant;
   logic              fill_grant;
   logic              fill_abort;
   logic              start_accept;
   logic              cnt_clear;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              mem_wr_q;

   // The loader is always welcome when idle; during a fill it only gets the
   // slot after the fill has had its turn, which gives strict alternation.
   assign ld_ready   = (state_q == FB_IDLE) || (last_grant_q == GNT_FILL);
   assign ld_grant   = bus.LdValid && ld_ready;

`ifdef FB_FILL_ABORT_EN
   assign fill_abort = FillAbort && (state_q == FB_FILL);
`else
   assign fill_abort = 1'b0;
`endif

   assign fill_grant   = (state_q == FB_FILL) && !ld_grant && !fill_abort;
   // A start request landing on the FillDone cycle belongs to the fill that
   // just finished and is dropped.
   assign start_accept = (state_q == FB_IDLE) && FillStart && !FillDone;
   assign cnt_clear    = start_accept || (fill_grant && fill_last) || fill_abort;

   fb_fill_counter #(
      .W     (ADDR_W),
      .DEPTH (FILL_DEPTH)
   ) u_counter (
      .clk      (Clock),
      .rst_n    (ResetN),
      .clear    (cnt_clear),
      .enable   (fill_grant),
      .count    (fill_count),
      .terminal (fill_last)
   );

   // Control FSM with registered fill status and round-robin grant memory.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= FB_IDLE;
         last_grant_q <= GNT_LOADER;
         fill_byte_q  <= '0;
         FillBusy     <= 1'b0;
         FillDone     <= 1'b0;
      end else begin
         FillDone <= fill_grant && fill_last;
         if (ld_grant) begin
            last_grant_q <= GNT_LOADER;
         end else if (fill_grant) begin
            last_grant_q <= GNT_FILL;
         end
         case (state_q)
            FB_IDLE: begin
               if (start_accept) begin
                  state_q     <= FB_FILL;
                  fill_byte_q <= FillData;
                  FillBusy    <= 1'b1;
               end
            end
            FB_FILL: begin
               if (fill_abort || (fill_grant && fill_last)) begin
                  state_q  <= FB_IDLE;
                  FillBusy <= 1'b0;
               end
            end
            default: begin
               state_q  <= FB_IDLE;
               FillBusy <= 1'b0;
            end
         endcase
      end
   end

   // Memory port register: the granted write appears one cycle later, and
   // address/data hold their last value when nobody is granted.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         mem_wr_q <= ld_grant || fill_grant;
         if (ld_grant) begin
            mem_addr_q <= bus.LdAddr;
            mem_data_q <= bus.LdData;
         end else if (fill_grant) begin
            mem_addr_q <= fill_count;
            mem_data_q <= fill_byte_q;
         end
      end
   end

   assign bus.LdReady    = ld_ready;
   assign bus.MemAddress = mem_addr_q;
   assign bus.MemData    = mem_data_q;
   assign bus.MemWr      = mem_wr_q;
   assign bus.MemClockEn = mem_wr_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter with a 16-byte fill depth.
module tb_fb_write_arbiter;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          Clock = 1'b0;
   logic          ResetN;
   logic          FillStart;
   logic [DW-1:0] FillData;
   logic          FillBusy;
   logic          FillDone;
`ifdef FB_FILL_ABORT_EN
   logic          FillAbort;
`endif

   fb_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fb_write_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FILL_DEPTH (DEPTH)
   ) dut (
      .Clock     (Clock),
      .ResetN    (ResetN),
      .bus       (bus),
      .FillStart (FillStart),
      .FillData  (FillData),
`ifdef FB_FILL_ABORT_EN
      .FillAbort (FillAbort),
`endif
      .FillBusy  (FillBusy),
      .FillDone  (FillDone)
   );

   // Free-running 10-time-unit clock.
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // Reference model: whether a fill is running, its next address, its byte,
   // and whether the fill owned the previous granted slot.
   bit          m_fill;
   bit          m_last_fill;
   int          m_cnt;
   logic [DW-1:0] m_byte;
   bit          e_wr, e_busy, e_done, e_ready;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;

   task automatic model_reset();
      m_fill = 0; m_last_fill = 0; m_cnt = 0; m_byte = '0;
      e_wr = 0; e_busy = 0; e_done = 0; e_ready = 1; e_addr = '0; e_data = '0;
   endtask

   task automatic model_step();
      bit ready, lg, fg, start;
      ready = !m_fill || m_last_fill;
      lg    = bus.LdValid && ready;
      fg    = m_fill && !lg;
      start = !m_fill && FillStart && !e_done;
      if (lg) begin
         e_addr = bus.LdAddr; e_data = bus.LdData; m_last_fill = 0;
      end else if (fg) begin
         e_addr = AW'(m_cnt); e_data = m_byte; m_last_fill = 1;
      end
      e_wr   = lg || fg;
      e_done = fg && (m_cnt == DEPTH - 1);
      if (start) begin
         m_fill = 1; m_cnt = 0; m_byte = FillData;
      end else if (fg) begin
         if (m_cnt == DEPTH - 1) begin
            m_fill = 0; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      e_busy  = m_fill;
      e_ready = !m_fill || m_last_fill;
   endtask

   task automatic tick();
      model_step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic applyStimulus(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input bit fs, input logic [DW-1:0] fd);
      bus.LdValid = v; bus.LdAddr = a; bus.LdData = d; FillStart = fs; FillData = fd;
   endtask

   task automatic test_reset();
      ResetN = 1'b0;
      applyStimulus(0, '0, '0, 0, '0);
`ifdef FB_FILL_ABORT_EN
      FillAbort = 1'b0;
`endif
      model_reset();
      repeat (2) @(negedge Clock);
      checks++;
      if ({bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady} !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 00001",
                  {bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady});
      end
      checks++;
      if (bus.MemAddress !== 12'h000 || bus.MemData !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_bus got %h/%h want 000/00", bus.MemAddress, bus.MemData);
      end
      ResetN = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_single_write();
      applyStimulus(1, 12'h123, 8'hA5, 0, '0);
      tick();
      bus.LdValid = 1'b0;
      checks++;
      if ({bus.MemWr, bus.MemClockEn, bus.MemAddress, bus.MemData} !== {1'b1, 1'b1, 12'h123, 8'hA5}) begin
         errors++;
         $display("[TB] FAIL single_write got wr=%b ce=%b %h/%h want 1 1 123/A5",
                  bus.MemWr, bus.MemClockEn, bus.MemAddress, bus.MemData);
      end
      tick();
      checks++;
      if (bus.MemWr !== 1'b0 || bus.MemAddress !== 12'h123 || bus.MemData !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL single_idle got wr=%b %h/%h want 0 123/A5",
                  bus.MemWr, bus.MemAddress, bus.MemData);
      end
   endtask

   task automatic test_full_fill();
      int writes = 0, dones = 0, busy_wr = 0, bad_seq = 0, done_addr = -1;
      applyStimulus(0, '0, '0, 1, 8'h3C);
      tick();
      FillStart = 1'b0;
      for (int c = 0; c < 22; c++) begin
         checks++;
         if ({bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData} !==
             {e_wr, e_busy, e_done, e_ready, e_addr, e_data}) begin
            errors++;
            $display("[TB] FAIL full_fill_cyc%0d got %b%b%b%b %h/%h want %b%b%b%b %h/%h", c,
                     bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData,
                     e_wr, e_busy, e_done, e_ready, e_addr, e_data);
         end
         if (bus.MemWr) begin
            if (bus.MemAddress !== AW'(writes) || bus.MemData !== 8'h3C) bad_seq++;
            if (FillBusy) busy_wr++;
            writes++;
         end
         if (FillDone) begin
            dones++;
            done_addr = int'(bus.MemAddress);
         end
         tick();
      end
      checks++;
      if (writes != 16 || bad_seq != 0) begin
         errors++;
         $display("[TB] FAIL full_fill_writes got %0d (bad %0d) want 16 (bad 0)", writes, bad_seq);
      end
      checks++;
      if (dones != 1 || done_addr != 15) begin
         errors++;
         $display("[TB] FAIL full_fill_done got %0d at %0d want 1 at 15", dones, done_addr);
      end
      checks++;
      if (busy_wr != 15) begin
         errors++;
         $display("[TB] FAIL full_fill_busy got %0d want 15", busy_wr);
      end
   endtask

   task automatic test_contention();
      int k = 0, ld_w = 0, fill_w = 0, total = 0, alt_bad = 0, total_at_done = -1;
      bit prev_ld = 0, acc;
      applyStimulus(1, 12'h800, DW'($urandom), 1, 8'h3C);
      for (int c = 0; c < 40; c++) begin
         acc = bus.LdValid && bus.LdReady;
         tick();
         FillStart = 1'b0;
         if (acc) begin
            k++;
            bus.LdAddr = 12'h800 + AW'(k);
            bus.LdData = DW'($urandom);
         end
         checks++;
         if ({bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData} !==
             {e_wr, e_busy, e_done, e_ready, e_addr, e_data}) begin
            errors++;
            $display("[TB] FAIL contention_cyc%0d got %b%b%b%b %h/%h want %b%b%b%b %h/%h", c,
                     bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData,
                     e_wr, e_busy, e_done, e_ready, e_addr, e_data);
         end
         if (bus.MemWr) begin
            if (total > 0 && prev_ld == bus.MemAddress[11]) alt_bad++;
            prev_ld = bus.MemAddress[11];
            if (bus.MemAddress[11]) ld_w++; else fill_w++;
            total++;
         end
         if (FillDone) begin
            total_at_done = total;
            bus.LdValid = 1'b0;
            break;
         end
      end
      checks++;
      if (total_at_done != 32 || ld_w != 16 || fill_w != 16 || alt_bad != 0) begin
         errors++;
         $display("[TB] FAIL contention_counts got total=%0d ld=%0d fill=%0d alt_bad=%0d want 32 16 16 0",
                  total_at_done, ld_w, fill_w, alt_bad);
      end
      tick();
   endtask

   task automatic test_restart_ignored();
      int writes = 0, dones = 0, bad_data = 0, late_busy = 0;
      applyStimulus(0, '0, '0, 1, 8'h3C);
      tick();
      FillStart = 1'b0;
      for (int c = 0; c < 26; c++) begin
         checks++;
         if ({bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData} !==
             {e_wr, e_busy, e_done, e_ready, e_addr, e_data}) begin
            errors++;
            $display("[TB] FAIL restart_cyc%0d got %b%b%b%b %h/%h want %b%b%b%b %h/%h", c,
                     bus.MemWr, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData,
                     e_wr, e_busy, e_done, e_ready, e_addr, e_data);
         end
         if (dones > 0 && FillBusy) late_busy++;
         if (bus.MemWr) begin
            writes++;
            if (bus.MemData !== 8'h3C) bad_data++;
         end
         if (FillDone) dones++;
         FillStart = (writes == 5 && bus.MemWr) || FillDone;
         FillData  = 8'h77;
         tick();
      end
      FillStart = 1'b0;
      checks++;
      if (writes != 16 || bad_data != 0 || dones != 1 || late_busy != 0) begin
         errors++;
         $display("[TB] FAIL restart_ignored got w=%0d bad=%0d done=%0d late_busy=%0d want 16 0 1 0",
                  writes, bad_data, dones, late_busy);
      end
   endtask

   task automatic test_reset_mid_fill();
      int writes = 0, dones = 0;
      applyStimulus(0, '0, '0, 1, 8'h5A);
      tick();
      FillStart = 1'b0;
      for (int c = 0; c < 12 && writes < 7; c++) begin
         tick();
         if (bus.MemWr) writes++;
      end
      #2 ResetN = 1'b0;
      #1;
      checks++;
      if ({bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData} !==
          {5'b00001, 12'h000, 8'h00}) begin
         errors++;
         $display("[TB] FAIL midfill_async got %b%b%b%b%b %h/%h want 00001 000/00",
                  bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData);
      end
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge Clock);
         if (FillDone || FillBusy || bus.MemWr) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("[TB] FAIL midfill_quiet got %0d active cycles want 0", dones);
      end
      ResetN = 1'b1;
      @(negedge Clock);
      applyStimulus(0, '0, '0, 1, 8'hC3);
      tick();
      FillStart = 1'b0;
      tick();
      checks++;
      if (bus.MemWr !== 1'b1 || bus.MemAddress !== 12'h000 || bus.MemData !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL midfill_restart got wr=%b %h/%h want 1 000/C3",
                  bus.MemWr, bus.MemAddress, bus.MemData);
      end
      for (int c = 0; c < 18; c++) tick();
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 400; c++) begin
         applyStimulus(($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom),
                       ($urandom_range(0, 19) == 0), DW'($urandom));
         tick();
         checks++;
         if ({bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady, bus.MemAddress, bus.MemData} !==
             {e_wr, e_wr, e_busy, e_done, e_ready, e_addr, e_data}) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("[TB] FAIL random_cyc%0d got %b%b%b%b%b %h/%h want %b%b%b%b%b %h/%h", c,
                        bus.MemWr, bus.MemClockEn, FillBusy, FillDone, bus.LdReady, bus.MemAddress,
                        bus.MemData, e_wr, e_wr, e_busy, e_done, e_ready, e_addr, e_data);
         end
      end
      applyStimulus(0, '0, '0, 0, '0);
   endtask

   // Guard against a stuck run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Scenario sequence.
   initial begin
      test_reset();
      test_single_write();
      test_full_fill();
      test_contention();
      test_restart_ignored();
      test_reset_mid_fill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
